// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared widths and write-back types for the processor core
package params_pkg;

    localparam int REGISTER_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_EX,
        WB_MEM
    } wb_src_e;

    typedef struct packed {
        logic [REGISTER_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_rsp_queue.sv
// rtl/wb_rsp_queue.sv - 2-entry load response FIFO with sticky overflow flag
module wb_rsp_queue
    import params_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  wb_entry_t push_entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      empty_o,
    output logic      full_o,
    output logic      overflow_o
);

    wb_entry_t  mem_q [2];
    logic       rptr_q;
    logic       wptr_q;
    logic [1:0] count_q;
    logic       overflow_q;
    logic       do_push;
    logic       do_pop;

    assign empty_o    = (count_q == 2'd0);
    assign full_o     = (count_q == 2'd2);
    assign overflow_o = overflow_q;
    assign head_o     = mem_q[rptr_q];

    // A pop in the same cycle frees the slot the write pointer aims at when full.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q     <= 1'b0;
            wptr_q     <= 1'b0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wptr_q <= ~wptr_q;
            if (do_pop)  rptr_q <= ~rptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            if (push_i && !do_push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= push_entry_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write port arbiter for ALU, EX and load responses
module wb_arbiter #(
    parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
    parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      alu_wb_req_i,
    input  logic [REGISTER_WIDTH-1:0] alu_wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     alu_wb_data_i,
    input  logic                      ex_wb_req_i,
    input  logic [REGISTER_WIDTH-1:0] ex_wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     ex_wb_data_i,
    input  logic                      mem_rsp_valid_i,
    input  logic [REGISTER_WIDTH-1:0] mem_rsp_rd_i,
    input  logic [DATA_WIDTH-1:0]     mem_rsp_data_i,
    output logic                      alu_allowed_wb_o,
    output logic                      ex_allowed_wb_o,
    output logic                      mem_full_o,
    output logic                      overflow_o,
    output logic                      rf_we_o,
    output logic [REGISTER_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output params_pkg::wb_src_e       wb_src_o
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    params_pkg::wb_entry_t push_entry;
    params_pkg::wb_entry_t head;
    params_pkg::wb_src_e   winner;
    logic                  q_empty;
    logic                  starve;
    logic [WAIT_W-1:0]     alu_wait_q;
    logic [REGISTER_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0]     sel_data;

    assign push_entry.rd   = mem_rsp_rd_i;
    assign push_entry.data = mem_rsp_data_i;

    wb_rsp_queue u_rsp_queue (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (mem_rsp_valid_i),
        .push_entry_i (push_entry),
        .pop_i        (winner == params_pkg::WB_MEM),
        .head_o       (head),
        .empty_o      (q_empty),
        .full_o       (mem_full_o),
        .overflow_o   (overflow_o)
    );

    // A starved ALU jumps ahead of the queue head for exactly one grant.
    assign starve = alu_wb_req_i && (alu_wait_q == WAIT_MAX);

    always_comb begin
        winner   = params_pkg::WB_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (starve)            winner = params_pkg::WB_ALU;
        else if (!q_empty)     winner = params_pkg::WB_MEM;
        else if (ex_wb_req_i)  winner = params_pkg::WB_EX;
        else if (alu_wb_req_i) winner = params_pkg::WB_ALU;
        case (winner)
            params_pkg::WB_ALU: begin sel_rd = alu_wb_rd_i; sel_data = alu_wb_data_i; end
            params_pkg::WB_EX:  begin sel_rd = ex_wb_rd_i;  sel_data = ex_wb_data_i;  end
            params_pkg::WB_MEM: begin sel_rd = head.rd;     sel_data = head.data;     end
            default:            begin sel_rd = '0;          sel_data = '0;            end
        endcase
    end

    assign alu_allowed_wb_o = (winner == params_pkg::WB_ALU);
    assign ex_allowed_wb_o  = (winner == params_pkg::WB_EX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_wait_q <= '0;
        end else if (alu_wb_req_i && !alu_allowed_wb_o) begin
            if (alu_wait_q != WAIT_MAX) alu_wait_q <= alu_wait_q + 1'b1;
        end else begin
            alu_wait_q <= '0;
        end
    end

    // Writes to r0 still consume the grant but never reach the register file.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            wb_src_o   <= params_pkg::WB_NONE;
        end else begin
            rf_we_o    <= (winner != params_pkg::WB_NONE) && (sel_rd != '0);
            rf_waddr_o <= sel_rd;
            rf_wdata_o <= sel_data;
            wb_src_o   <= winner;
        end
    end

endmodule
